logic_resp_checker: RTL and testbench

Synthesizable response checker for small combinational or pipelined logic DUTs under bench-driven stimulus. It accepts each applied input vector and samples the DUT output a fixed number of cycles later. Each sample is compared against a parameterized truth table. The block accumulates vector and error counts, captures the first failing vector, and reports a registered pass/done verdict. It sits beside the DUT in gate-level test harnesses and checks the vectors that the stimulus driver applies.

---
 rtl/logic_chk_pkg.sv | 24 ++
 rtl/lat_pipe.sv | 65 ++++++
 rtl/logic_resp_checker.sv | 168 ++++++++++++++++
 tb/tb_logic_resp_checker.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_chk_pkg.sv
// Shared types and helpers for logic_resp_checker and its latency pipeline.
package logic_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  localparam int LAT_MAX = 7;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    logic [31:0] res;
    if (val >= max_val) begin
      res = val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/lat_pipe.sv
// LAT-deep {valid, data} shift pipeline with synchronous clear.
// LAT=0 is a combinational pass-through.
module lat_pipe
  import logic_chk_pkg::*;
#(
  parameter int LAT = 0,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         any_valid
);

  localparam int DEPTH = (LAT > LAT_MAX) ? LAT_MAX : LAT;

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_bits;
      assign unused_bits = ^{clk, rst, clr};
      assign out_valid   = in_valid;
      assign out_data    = in_data;
      assign any_valid   = 1'b0;
    end else begin : g_pipe
      logic [DEPTH-1:0]        valid_q, valid_d;
      logic [DEPTH-1:0][W-1:0] data_q, data_d;

      // Stage 0 takes the new entry, every later stage takes its predecessor.
      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr) begin
          valid_d = {DEPTH{1'b0}};
        end else begin
          valid_d[0] = in_valid;
          data_d[0]  = in_data;
          for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
          end
        end
      end

      // Pipeline state registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= {DEPTH{1'b0}};
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end

      assign out_valid = valid_q[DEPTH-1];
      assign out_data  = data_q[DEPTH-1];
      assign any_valid = |valid_q;
    end
  endgenerate

endmodule

// File: rtl/logic_resp_checker.sv
// Compares a DUT's 1-bit response against a truth table LAT cycles after each vector.
// Define CHECKER_COVERAGE_EN to track per-vector coverage and require full coverage for pass.
module logic_resp_checker
  import logic_chk_pkg::*;
#(
  parameter int                   N_IN      = 2,
  parameter logic [(2**N_IN)-1:0] EXP_TABLE = 4'b1000,
  parameter int                   LAT       = 0,
  parameter int                   CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 stim_valid,
  input  logic [N_IN-1:0]      stim,
  input  logic                 resp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     vec_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 first_err_valid,
  output logic [N_IN-1:0]      first_err_vec,
  output logic [(2**N_IN)-1:0] cov
);

  localparam int          NV      = 2**N_IN;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  chk_state_e       state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d, err_cnt_q, err_cnt_d;
  logic             first_err_valid_q, first_err_valid_d;
  logic [N_IN-1:0]  first_err_vec_q, first_err_vec_d;

  logic            accept, chk_fire, mismatch, pipe_out_valid, pipe_any, cov_full;
  logic [N_IN-1:0] pipe_out_data;

  // A restart in the same cycle drops the vector along with everything else.
  assign accept   = (state_q == RUN) && stim_valid && !start;
  assign chk_fire = pipe_out_valid && !start;
  assign mismatch = (resp != EXP_TABLE[pipe_out_data]);

  lat_pipe #(.LAT(LAT), .W(N_IN)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .in_valid  (accept),
    .in_data   (stim),
    .out_valid (pipe_out_valid),
    .out_data  (pipe_out_data),
    .any_valid (pipe_any)
  );

`ifdef CHECKER_COVERAGE_EN
  logic [NV-1:0] cov_q, cov_d;

  // Mark each vector index that reaches the compare stage.
  always_comb begin
    cov_d = cov_q;
    if (start) begin
      cov_d = {NV{1'b0}};
    end else if (chk_fire) begin
      cov_d = cov_q | (NV'(1'b1) << pipe_out_data);
    end else begin
      cov_d = cov_q;
    end
  end

  // Coverage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cov_q <= {NV{1'b0}};
    end else begin
      cov_q <= cov_d;
    end
  end

  assign cov      = cov_q;
  assign cov_full = &cov_q;
`else
  assign cov      = {NV{1'b0}};
  assign cov_full = 1'b1;
`endif

  // Next-state, compare bookkeeping and verdict.
  always_comb begin
    state_d           = state_q;
    vec_cnt_d         = vec_cnt_q;
    err_cnt_d         = err_cnt_q;
    first_err_valid_d = first_err_valid_q;
    first_err_vec_d   = first_err_vec_q;
    pass_d            = pass_q;
    if (start) begin
      state_d           = RUN;
      vec_cnt_d         = {CNT_W{1'b0}};
      err_cnt_d         = {CNT_W{1'b0}};
      first_err_valid_d = 1'b0;
      first_err_vec_d   = {N_IN{1'b0}};
      pass_d            = 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     state_d = stop ? DRAIN : RUN;
        DRAIN:   state_d = pipe_any ? DRAIN : DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
      if (chk_fire) begin
        vec_cnt_d = CNT_W'(sat_inc(32'(vec_cnt_q), CNT_MAX));
        if (mismatch) begin
          err_cnt_d = CNT_W'(sat_inc(32'(err_cnt_q), CNT_MAX));
          if (!first_err_valid_q) begin
            first_err_valid_d = 1'b1;
            first_err_vec_d   = pipe_out_data;
          end else begin
            first_err_valid_d = first_err_valid_q;
          end
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end else begin
        vec_cnt_d = vec_cnt_q;
      end
      // Counters have already absorbed the last check when DRAIN sees an empty pipe.
      if ((state_q == DRAIN) && !pipe_any) begin
        pass_d = (err_cnt_q == {CNT_W{1'b0}}) && (vec_cnt_q != {CNT_W{1'b0}}) && cov_full;
      end else begin
        pass_d = pass_q;
      end
    end
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // FSM, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      vec_cnt_q         <= {CNT_W{1'b0}};
      err_cnt_q         <= {CNT_W{1'b0}};
      first_err_valid_q <= 1'b0;
      first_err_vec_q   <= {N_IN{1'b0}};
    end else begin
      state_q           <= state_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      pass_q            <= pass_d;
      vec_cnt_q         <= vec_cnt_d;
      err_cnt_q         <= err_cnt_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_vec_q   <= first_err_vec_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign vec_cnt         = vec_cnt_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_vec   = first_err_vec_q;

endmodule

// File: tb/tb_logic_resp_checker.sv
// Bench for logic_resp_checker: instance A (LAT=0, CNT_W=4) and instance B (LAT=3, CNT_W=8)
// share stimulus; each run's expected results are queued and checked when done rises.
module tb_logic_resp_checker;

  localparam int LAT_A = 0;
  localparam int CW_A  = 4;
  localparam int LAT_B = 3;
  localparam int CW_B  = 8;

  typedef struct {
    int         vec;
    int         err;
    bit         fev_v;
    logic [1:0] fev;
    bit         pass;
    logic [3:0] cov;
    int         done_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, stop = 1'b0, stim_valid = 1'b0;
  logic       resp_a = 1'b0, resp_b = 1'b0;
  logic [1:0] stim = 2'd0;

  logic       busy_a, done_a, pass_a, fev_v_a;
  logic [3:0] vec_a, err_a, cov_a;
  logic [1:0] fev_a;
  logic       busy_b, done_b, pass_b, fev_v_b;
  logic [7:0] vec_b, err_b;
  logic [3:0] cov_b;
  logic [1:0] fev_b;

  logic_resp_checker #(.N_IN(2), .EXP_TABLE(4'b1000), .LAT(LAT_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .stim_valid(stim_valid), .stim(stim),
    .resp(resp_a), .busy(busy_a), .done(done_a), .pass(pass_a), .vec_cnt(vec_a), .err_cnt(err_a),
    .first_err_valid(fev_v_a), .first_err_vec(fev_a), .cov(cov_a));

  logic_resp_checker #(.N_IN(2), .EXP_TABLE(4'b1000), .LAT(LAT_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .stim_valid(stim_valid), .stim(stim),
    .resp(resp_b), .busy(busy_b), .done(done_b), .pass(pass_b), .vec_cnt(vec_b), .err_cnt(err_b),
    .first_err_valid(fev_v_b), .first_err_vec(fev_b), .cov(cov_b));

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  exp_t       q_a[$], q_b[$];
  logic [1:0] acc_v[$];
  bit         acc_ok[$];
  int         acc_cyc[$];
  bit         running = 1'b0;
  int         stop_c = 0;
  logic       rhist[$];
  logic [1:0] plan_v[$];
  bit         plan_good[$];
  int         plan_gap[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_run(input string tag, input exp_t e, input logic busy, input logic pass,
                           input logic [7:0] vec, input logic [7:0] err, input logic fv,
                           input logic [1:0] fev, input logic [3:0] cov);
    check({tag, "_done_cycle"}, cyc_n, e.done_cyc);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_vec_cnt"}, vec, e.vec);
    check({tag, "_err_cnt"}, err, e.err);
    check({tag, "_first_err_valid"}, fv, e.fev_v);
    check({tag, "_first_err_vec"}, fev, e.fev);
    check({tag, "_pass"}, pass, e.pass);
    check({tag, "_cov"}, cov, e.cov);
  endtask

  // Scoreboard monitors: one per instance, triggered by a rising done.
  logic done_a_prev = 1'b0;
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (done_a && !done_a_prev) begin
      if (q_a.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_unexpected_done: got done=1 at cycle %0d, expected no run to finish", cyc_n);
      end else begin
        e = q_a.pop_front();
        check_run("a", e, busy_a, pass_a, {4'd0, vec_a}, {4'd0, err_a}, fev_v_a, fev_a, cov_a);
      end
    end
    done_a_prev = done_a;
  end

  logic done_b_prev = 1'b0;
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (done_b && !done_b_prev) begin
      if (q_b.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_unexpected_done: got done=1 at cycle %0d, expected no run to finish", cyc_n);
      end else begin
        e = q_b.pop_front();
        check_run("b", e, busy_b, pass_b, vec_b, err_b, fev_v_b, fev_b, cov_b);
      end
    end
    done_b_prev = done_b;
  end

  // One clock of stimulus; resp_b replays the intended response LAT_B cycles later.
  task automatic drive(input logic rs, input logic st, input logic sp, input logic v,
                       input logic [1:0] s, input logic r);
    @(posedge clk);
    #1;
    rst = rs; start = st; stop = sp; stim_valid = v; stim = s;
    rhist.push_back(r);
    resp_a = r;
    resp_b = (rhist.size() > LAT_B) ? rhist[rhist.size() - 1 - LAT_B] : 1'b0;
    if (rhist.size() > 8) void'(rhist.pop_front());
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'($urandom), 1'($urandom));
  endtask

  // Reference: the checked function is a 2-input AND.
  task automatic apply(input logic [1:0] s, input bit good, input bit sp);
    logic r;
    r = good ? (&s) : ~(&s);
    drive(1'b0, 1'b0, sp, 1'b1, s, r);
    if (running) begin
      acc_v.push_back(s);
      acc_ok.push_back(good);
      acc_cyc.push_back(cyc_n);
    end
    if (sp) stop_c = cyc_n;
  endtask

  function automatic exp_t model(input int lat, input int cw);
    exp_t       e;
    int         errs = 0;
    int         n = acc_v.size();
    int         mx = (1 << cw) - 1;
    int         last;
    logic [3:0] c = 4'd0;
    e.fev_v = 1'b0;
    e.fev   = 2'd0;
    for (int i = 0; i < n; i++) begin
      c[acc_v[i]] = 1'b1;
      if (!acc_ok[i]) begin
        errs++;
        if (!e.fev_v) begin
          e.fev_v = 1'b1;
          e.fev   = acc_v[i];
        end
      end
    end
    e.vec = (n > mx) ? mx : n;
    e.err = (errs > mx) ? mx : errs;
`ifdef CHECKER_COVERAGE_EN
    e.cov  = c;
    e.pass = (errs == 0) && (n > 0) && (c == 4'hF);
`else
    e.cov  = 4'd0;
    e.pass = (errs == 0) && (n > 0);
`endif
    last = (n > 0) ? acc_cyc[n-1] + lat : 0;
    e.done_cyc = ((last > stop_c) ? last : stop_c) + 2;
    return e;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_busy_a"}, busy_a, 1'b0);   check({tag, "_busy_b"}, busy_b, 1'b0);
    check({tag, "_done_a"}, done_a, 1'b0);   check({tag, "_done_b"}, done_b, 1'b0);
    check({tag, "_pass_a"}, pass_a, 1'b0);   check({tag, "_pass_b"}, pass_b, 1'b0);
    check({tag, "_vec_a"}, vec_a, 4'd0);     check({tag, "_vec_b"}, vec_b, 8'd0);
    check({tag, "_err_a"}, err_a, 4'd0);     check({tag, "_err_b"}, err_b, 8'd0);
    check({tag, "_fev_v_a"}, fev_v_a, 1'b0); check({tag, "_fev_v_b"}, fev_v_b, 1'b0);
    check({tag, "_fev_a"}, fev_a, 2'd0);     check({tag, "_fev_b"}, fev_b, 2'd0);
    check({tag, "_cov_a"}, cov_a, 4'd0);     check({tag, "_cov_b"}, cov_b, 4'd0);
  endtask

  // start may coincide with stop; start has priority.
  task automatic begin_run();
    drive(1'b0, 1'b1, 1'($urandom), 1'b0, 2'd0, 1'b0);
    running = 1'b1;
    acc_v.delete(); acc_ok.delete(); acc_cyc.delete();
    idle();
    @(negedge clk);
    check("start_busy_a", busy_a, 1'b1); check("start_busy_b", busy_b, 1'b1);
    check("start_done_a", done_a, 1'b0); check("start_done_b", done_b, 1'b0);
    check("start_vec_a", vec_a, 4'd0);   check("start_vec_b", vec_b, 8'd0);
    check("start_err_a", err_a, 4'd0);   check("start_err_b", err_b, 8'd0);
  endtask

  task automatic end_run(input bit stopped);
    exp_t ea, eb;
    if (!stopped) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 2'($urandom), 1'($urandom));
      stop_c = cyc_n;
    end
    running = 1'b0;
    ea = model(LAT_A, CW_A);
    eb = model(LAT_B, CW_B);
    q_a.push_back(ea);
    q_b.push_back(eb);
    // Junk stim_valid while draining/done must be ignored.
    for (int k = 0; k < 40; k++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      drive(1'b0, 1'b0, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom));
    end
    check("done_seen_pending", 32'(q_a.size() + q_b.size()), 32'd0);
    q_a.delete(); q_b.delete();
    idle(); idle();
    @(negedge clk);
    check("hold_done_a", done_a, 1'b1); check("hold_done_b", done_b, 1'b1);
    check("hold_vec_a", {4'd0, vec_a}, ea.vec); check("hold_vec_b", vec_b, eb.vec);
    check("hold_pass_a", pass_a, ea.pass);      check("hold_pass_b", pass_b, eb.pass);
  endtask

  task automatic add(input logic [1:0] v, input bit good, input int gap);
    plan_v.push_back(v); plan_good.push_back(good); plan_gap.push_back(gap);
  endtask

  task automatic exec_plan(input bit stop_last);
    bit stopped;
    begin_run();
    for (int i = 0; i < plan_v.size(); i++) begin
      for (int g = 0; g < plan_gap[i]; g++) idle();
      apply(plan_v[i], plan_good[i], stop_last && (i == plan_v.size() - 1));
    end
    stopped = stop_last && (plan_v.size() > 0);
    plan_v.delete(); plan_good.delete(); plan_gap.delete();
    end_run(stopped);
  endtask

  initial begin
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    idle();
    @(negedge clk);
    check_reset("por");

    // Exhaustive, all correct, separate stop.
    for (int v = 0; v < 4; v++) add(2'(v), 1'b1, 0);
    exec_plan(1'b0);
    // Single fault on vector 2, stop with the last vector.
    for (int v = 0; v < 4; v++) add(2'(v), (v != 2), 0);
    exec_plan(1'b1);
    // Coverage gap: only vectors 0 and 3.
    add(2'd0, 1'b1, 0); add(2'd3, 1'b1, 1);
    exec_plan(1'b0);
    // Saturation: 20 wrong vectors.
    for (int i = 0; i < 20; i++) add(2'($urandom), 1'b0, 0);
    exec_plan(1'b1);
    // Empty run.
    exec_plan(1'b0);

    // Reset with vectors in flight; the following run must not see them.
    begin_run();
    apply(2'd1, 1'b0, 1'b0); apply(2'd3, 1'b0, 1'b0); apply(2'd2, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
    running = 1'b0;
    acc_v.delete(); acc_ok.delete(); acc_cyc.delete();
    idle();
    @(negedge clk);
    check_reset("midrun_rst");
    add(2'd3, 1'b1, 0);
    exec_plan(1'b1);

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      int n;
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++)
        add(2'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      exec_plan(1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected the bench to finish first");
    $fatal(1);
  end

endmodule
